// File: rtl/sub_serial_if.sv
// sub_serial_if: request/operand/result bundle between a requester and the bit-serial subtractor
interface sub_serial_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] out;
    logic             borrow_out;
    logic             done;
    logic             busy;

    modport master (output en, a, b, input out, borrow_out, done, busy);
    modport slave  (input en, a, b, output out, borrow_out, done, busy);
endinterface

// File: rtl/sub_serial.sv
// sub_serial: bit-serial a - b, LSB first, one bit per clock, with final borrow flag
module sub_serial #(
    parameter int WIDTH = 8,
    parameter int CW    = 3
) (
    input logic        clk,
    input logic        rst,
    sub_serial_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, SUB = 2'd1, DONE = 2'd2} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, out_q, out_d;
    logic [CW-1:0]    count_q, count_d;
    logic             borrow_q, borrow_d, borrow_out_q, borrow_out_d;
    logic             diff_bit, borrow_nx;

    assign diff_bit  = a_q[0] ^ b_q[0] ^ borrow_q;
    assign borrow_nx = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & borrow_q);

    // Next-state: load on request in IDLE, shift one bit per edge in SUB, wait for en low in DONE
    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        out_d        = out_q;
        count_d      = count_q;
        borrow_d     = borrow_q;
        borrow_out_d = borrow_out_q;
        case (state_q)
            IDLE: if (bus.en) begin
                a_d          = bus.a;
                b_d          = bus.b;
                out_d        = '0;
                count_d      = '0;
                borrow_d     = 1'b0;
                borrow_out_d = 1'b0;
                state_d      = SUB;
            end
            SUB: begin
                out_d    = {diff_bit, out_q[WIDTH-1:1]};
                a_d      = a_q >> 1;
                b_d      = b_q >> 1;
                borrow_d = borrow_nx;
                count_d  = count_q + CW'(1);
                if (count_q == CW'(WIDTH - 1)) begin
                    borrow_out_d = borrow_nx;
                    state_d      = DONE;
                end
            end
            DONE: state_d = bus.en ? DONE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset clears any partial result
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            out_q        <= '0;
            count_q      <= '0;
            borrow_q     <= 1'b0;
            borrow_out_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            out_q        <= out_d;
            count_q      <= count_d;
            borrow_q     <= borrow_d;
            borrow_out_q <= borrow_out_d;
        end
    end

    assign bus.out        = out_q;
    assign bus.borrow_out = borrow_out_q;
    assign bus.done       = (state_q == DONE);
    assign bus.busy       = (state_q == SUB);
endmodule

// File: doc/sub_serial.md
Name: sub_serial

Overview:
- Bit-serial 8-bit subtractor: computes out = a - b (mod 2^WIDTH), one bit per clock, LSB first, and flags a borrow.
- Inverse-operation companion to the bit-serial adder in the arithmetic datapath.
- Uses the same load / shift / done control style and the same en-driven request.
- The requester holds en high until done, then drops en (four-phase handshake).

Parameters:
- WIDTH, 8, operand and result width in bits.
- CW, 3, counter width; must equal clog2(WIDTH).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- en  input  1  request; sampled in IDLE and DONE.
- a  input  WIDTH  minuend; captured only on the load edge.
- b  input  WIDTH  subtrahend; captured only on the load edge.
- out  output  WIDTH  registered difference.
- borrow_out  output  1  registered final borrow; 1 iff a < b (unsigned).
- done  output  1  high while FSM is in DONE.
- busy  output  1  high while FSM is in SUB.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - a_reg, b_reg, out, count, borrow, borrow_out = 0.
  - done=0, busy=0.
  - Reset mid-operation discards the partial result; no residue survives.
- FSM states: IDLE(0), SUB(1), DONE(2). Unused encodings return to IDLE on the next edge.
- IDLE:
  - en=1: load a_reg<=a, b_reg<=b, out<=0, count<=0, borrow<=0, borrow_out<=0; go SUB.
  - en=0: hold all registers.
- SUB, per edge:
  - d = a_reg[0] ^ b_reg[0] ^ borrow.
  - borrow <= (~a_reg[0] & b_reg[0]) | (~(a_reg[0]^b_reg[0]) & borrow).
  - out <= {d, out[WIDTH-1:1]}.
  - a_reg <= a_reg>>1; b_reg <= b_reg>>1.
  - count <= count+1.
  - When count==WIDTH-1 at the edge: go DONE and set borrow_out <= borrow_next, the value being written to borrow that edge.
  - en, a and b are ignored throughout SUB.
- DONE:
  - out and borrow_out hold.
  - en=1: stay in DONE.
  - en=0: go IDLE; out and borrow_out keep their value until the next load.
  - A new request requires en to be seen low in DONE (go IDLE) and then high in IDLE.
- Latency:
  - en sampled high in IDLE at edge E; SUB occupies edges E+1..E+WIDTH.
  - done rises after edge E+WIDTH, i.e. WIDTH+1 cycles after the request.
  - out is final when done rises.
- Output decode: done and busy are decodes of the state register only, with no input-to-output combinational path.
- Arithmetic: result is modulo 2^WIDTH.
  - a==b gives out=0, borrow_out=0.
  - b=0 gives out=a, borrow_out=0.
  - a=0, b!=0 gives out=2^WIDTH-b, borrow_out=1.
- Simultaneous events:
  - rst asserted on any edge overrides everything.
  - en rising in the same cycle as the SUB->DONE transition has no effect until DONE has been exited through IDLE.

Test Plan:
- Reset, then a=200, b=55, en held high: busy for 8 cycles, done after 9 cycles -> out=145 (0x91), borrow_out=0. Drop en -> IDLE next edge with out still 0x91.
- a=55, b=200 -> out=0x6F (111), borrow_out=1. Also a=0x00, b=0x01 -> out=0xFF, borrow_out=1.
- a=b=0xA5 -> out=0x00, borrow_out=0. Also a=0x3C, b=0x00 -> out=0x3C, borrow_out=0.
- Start a=200, b=55. During SUB toggle en and change a, b to random values every cycle, holding en high from the final SUB cycle onward -> result still 0x91, done timing unchanged. Holding en high in DONE keeps done=1 indefinitely with out stable.
- Assert rst (0) asynchronously mid-edge after the 4th SUB cycle -> all outputs 0 immediately, state IDLE. Release, then issue a=10, b=3 -> out=7, borrow_out=0, with no corruption from the aborted run.
- Back-to-back requests: 100-1, drop en for exactly one cycle in DONE, then 1-100 -> out=99 then out=0x9D (157), borrow_out=1. Verify the gap is one IDLE cycle and the second result has the same WIDTH+1 latency.
